responder_ctrl: RTL and testbench
=================================

// Module: responder_ctrl
// PURPOSE
//   Quiz-responder sequencer: arms the answer window on host Start, loads the preset BCD
//   countdown (TimerH_Set/TimerL_Set from the time-select block), locks the first contestant
//   key, flags early presses (fouls) and timeouts. Feeds the display and buzzer blocks.
// PARAMETERS
//   N_PLAYERS  6           number of contestant keys (1..7)
//   TICK_DIV   50_000_000  CLK cycles per 1 s countdown tick (>=2)
// PORTS
//   CLK          in   1   system clock, all logic on rising edge
//   RSTn         in   1   asynchronous active-low reset
//   Start        in   1   host start, level; rising edge acts (debounced/synchronous upstream)
//   Clear        in   1   host clear, level; acts while high
//   Key          in   N   contestant keys, bit i = player i+1; rising edge acts
//   TimerH_Set   in   4   preset tens digit, BCD
//   TimerL_Set   in   4   preset units digit, BCD
//   State        out  3   current FSM state code
//   Winner_ID    out  3   answering/fouling player 1..N, 0 = none
//   Foul         out  1   high in FOUL state
//   Timeout      out  1   high in TIMEOUT state
//   TimeH        out  4   remaining time tens digit, BCD
//   TimeL        out  4   remaining time units digit, BCD
//   Beep         out  1   one-cycle pulse on entering LOCKED, FOUL or TIMEOUT
// BEHAVIOUR
//   Reset: State=IDLE(0), Winner_ID=0, Foul=0, Timeout=0, TimeH=0, TimeL=0, Beep=0, tick cnt=0,
//     edge registers=0 (a key already held at reset release does not create an edge).
//   Edge detect: start_e = Start & ~start_q; key_e = Key & ~key_q; q regs updated every cycle.
//   States: IDLE=0, ARMED=1, LOCKED=2, FOUL=3, TIMEOUT=4.
//   Clear high: any state -> IDLE next cycle, outputs to reset values; overrides all else.
//   IDLE: key_e!=0 -> FOUL, Winner_ID = lowest set index+1 (foul beats Start same cycle);
//     else start_e -> ARMED, TimeH/TimeL <= preset (digit >9 clamped to 9), tick cnt <= 0.
//   ARMED: key_e!=0 -> LOCKED, Winner_ID = lowest set index+1, count frozen;
//     else if TimeH:TimeL==00 -> TIMEOUT; else on tick (cnt==TICK_DIV-1, cnt wraps to 0)
//     decrement BCD: L>0 ? L-1 : (L=9, H-1). Key beats tick/timeout in the same cycle.
//   LOCKED/FOUL/TIMEOUT: hold all outputs; Start and Key ignored; exit only via Clear.
//   Latency: key rising at clock edge n -> Winner_ID/State valid after edge n (1 cycle).
//     Timeout: preset 00 -> TIMEOUT one cycle after entering ARMED; preset HL -> TIMEOUT
//     (10H+L)*TICK_DIV+1 cycles after entering ARMED.
//   Tick counter runs only in ARMED; held at 0 elsewhere.
//   Beep = registered (next_state != state) & next_state in {LOCKED,FOUL,TIMEOUT}.
//   Foul=(State==FOUL), Timeout=(State==TIMEOUT), both registered.
//   Preset inputs sampled only on the IDLE->ARMED transition; later changes have no effect.
// STRUCTURE
//   responder_pkg: state encodings, ID width constant, BCD max digit (9).
//   Sub-module bcd_down_counter (load, tick enable, zero flag, 2 BCD digits); FSM, priority
//   encoder and tick divider stay in responder_ctrl.
// TESTING (TICK_DIV=4, N_PLAYERS=6)
//   1 preset 1/9, Start, Key[2] after 10 cycles -> LOCKED, Winner_ID=3, Beep 1 cycle, time frozen.
//   2 preset 0/2, Start, no keys -> 2->1->0 every 4 cycles, TIMEOUT 9 cycles after ARMED, Beep.
//   3 Key[4] pressed in IDLE -> FOUL, Winner_ID=5; later Start ignored; Clear -> IDLE, all 0.
//   4 Key[1] and Key[5] rise same cycle in ARMED -> Winner_ID=2; Key[0] after lock ignored.
//   5 preset 1/0 -> after one tick TimeH=0, TimeL=9 (borrow); preset 0/0 -> TIMEOUT next cycle.
//   6 RSTn low mid-ARMED -> all outputs 0 immediately (async); held key at release: no edge.

Source files
------------

// File: rtl/responder_pkg.sv
// Shared definitions for the quiz-responder sequencer: state codes,
// widths and the small helpers used by the controller and BCD counter.
package responder_pkg;

   // State codes as seen on the State output.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_LOCKED  = 3'd2,
      ST_FOUL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   localparam int         ID_W        = 3;     // player ID width, 0 = nobody
   localparam int         MAX_PLAYERS = 7;     // most keys an ID_W-bit ID can name
   localparam logic [3:0] BCD_MAX     = 4'd9;  // largest legal BCD digit

   // Out-of-range preset digits are treated as 9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   // Lowest set key wins; result is the 1-based player number, 0 if none.
   function automatic logic [ID_W-1:0] first_key_id(input logic [MAX_PLAYERS-1:0] keys);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
         if (keys[i]) id = ID_W'(i + 1);
      end
      return id;
   endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD countdown holding the remaining answer time. Loads a
// clamped preset, steps down by one second per enable, stops at 00.
module bcd_down_counter
   import responder_pkg::*;
(
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       i_clr,
   input  logic       i_load,
   input  logic [3:0] i_load_h,
   input  logic [3:0] i_load_l,
   input  logic       i_dec,
   output logic [3:0] o_h,
   output logic [3:0] o_l,
   output logic       o_zero
);

   logic [3:0] r_h;
   logic [3:0] r_l;

   assign o_zero = (r_h == 4'd0) && (r_l == 4'd0);
   assign o_h    = r_h;
   assign o_l    = r_l;

   // Clear beats load beats decrement; units digit borrows from tens.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_h <= 4'd0;
         r_l <= 4'd0;
      end else if (i_clr) begin
         r_h <= 4'd0;
         r_l <= 4'd0;
      end else if (i_load) begin
         r_h <= bcd_clamp(i_load_h);
         r_l <= bcd_clamp(i_load_l);
      end else if (i_dec && !o_zero) begin
         if (r_l != 4'd0) begin
            r_l <= r_l - 4'd1;
         end else begin
            r_l <= BCD_MAX;
            r_h <= r_h - 4'd1;
         end
      end
   end

endmodule

// File: rtl/responder_ctrl.sv
// Quiz-responder sequencer: arms the answer window on Start, counts the
// preset time down, locks the first contestant key and flags fouls and
// timeouts for the display and buzzer blocks.
module responder_ctrl
   import responder_pkg::*;
#(
   parameter int N_PLAYERS = 6,
   parameter int TICK_DIV  = 50_000_000
)(
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 Start,
   input  logic                 Clear,
   input  logic [N_PLAYERS-1:0] Key,
   input  logic [3:0]           TimerH_Set,
   input  logic [3:0]           TimerL_Set,
   output logic [2:0]           State,
   output logic [ID_W-1:0]      Winner_ID,
   output logic                 Foul,
   output logic                 Timeout,
   output logic [3:0]           TimeH,
   output logic [3:0]           TimeL,
   output logic                 Beep
);

   localparam int             CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   state_t                r_state;
   logic [ID_W-1:0]       r_winner;
   logic                  r_foul;
   logic                  r_timeout;
   logic                  r_beep;
   logic [CNT_W-1:0]      r_tick_cnt;
   logic                  r_start_q;
   logic [N_PLAYERS-1:0]  r_key_q;
   logic                  r_edge_en;

   logic                  w_start_e;
   logic [N_PLAYERS-1:0]  w_key_e;
   logic                  w_key_hit;
   logic [ID_W-1:0]       w_key_id;
   logic                  w_tick;
   logic                  w_zero;
   logic                  w_load;
   logic                  w_dec;

   // Input history for edge detection; edges are suppressed on the first
   // clock after reset so a key already held at release is not a press.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_start_q <= 1'b0;
         r_key_q   <= '0;
         r_edge_en <= 1'b0;
      end else begin
         r_start_q <= Start;
         r_key_q   <= Key;
         r_edge_en <= 1'b1;
      end
   end

   assign w_start_e = r_edge_en & Start & ~r_start_q;
   assign w_key_e   = {N_PLAYERS{r_edge_en}} & Key & ~r_key_q;
   assign w_key_hit = |w_key_e;
   assign w_key_id  = first_key_id(MAX_PLAYERS'(w_key_e));
   assign w_tick    = (r_tick_cnt == TICK_LAST);

   // Counter control mirrors the FSM priorities: Clear, then key, then time.
   assign w_load = !Clear && (r_state == ST_IDLE) && !w_key_hit && w_start_e;
   assign w_dec  = !Clear && (r_state == ST_ARMED) && !w_key_hit && !w_zero && w_tick;

   bcd_down_counter u_time (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .i_clr    (Clear),
      .i_load   (w_load),
      .i_load_h (TimerH_Set),
      .i_load_l (TimerL_Set),
      .i_dec    (w_dec),
      .o_h      (TimeH),
      .o_l      (TimeL),
      .o_zero   (w_zero)
   );

   // Sequencer FSM with registered flags, winner, beep and second divider.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state    <= ST_IDLE;
         r_winner   <= '0;
         r_foul     <= 1'b0;
         r_timeout  <= 1'b0;
         r_beep     <= 1'b0;
         r_tick_cnt <= '0;
      end else begin
         r_beep <= 1'b0;
         if (Clear) begin
            r_state    <= ST_IDLE;
            r_winner   <= '0;
            r_foul     <= 1'b0;
            r_timeout  <= 1'b0;
            r_tick_cnt <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_tick_cnt <= '0;
                  if (w_key_hit) begin
                     r_state  <= ST_FOUL;
                     r_winner <= w_key_id;
                     r_foul   <= 1'b1;
                     r_beep   <= 1'b1;
                  end else if (w_start_e) begin
                     r_state <= ST_ARMED;
                  end
               end
               ST_ARMED: begin
                  if (w_key_hit) begin
                     r_state    <= ST_LOCKED;
                     r_winner   <= w_key_id;
                     r_beep     <= 1'b1;
                     r_tick_cnt <= '0;
                  end else if (w_zero) begin
                     r_state    <= ST_TIMEOUT;
                     r_timeout  <= 1'b1;
                     r_beep     <= 1'b1;
                     r_tick_cnt <= '0;
                  end else if (w_tick) begin
                     r_tick_cnt <= '0;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               default: begin
                  r_tick_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign State     = r_state;
   assign Winner_ID = r_winner;
   assign Foul      = r_foul;
   assign Timeout   = r_timeout;
   assign Beep      = r_beep;

endmodule

// File: tb/tb_responder_ctrl.sv
// Bench for responder_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model that tracks the answer
// window as elapsed cycles and whole seconds remaining.
module tb_responder_ctrl;

   localparam int TD = 4;
   localparam int NP = 6;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic          Start;
   logic          Clear;
   logic [NP-1:0] Key;
   logic [3:0]    TimerH_Set;
   logic [3:0]    TimerL_Set;
   logic [2:0]    State;
   logic [2:0]    Winner_ID;
   logic          Foul;
   logic          Timeout;
   logic [3:0]    TimeH;
   logic [3:0]    TimeL;
   logic          Beep;

   always #5 CLK = ~CLK;

   responder_ctrl #(.N_PLAYERS(NP), .TICK_DIV(TD)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Start      (Start),
      .Clear      (Clear),
      .Key        (Key),
      .TimerH_Set (TimerH_Set),
      .TimerL_Set (TimerL_Set),
      .State      (State),
      .Winner_ID  (Winner_ID),
      .Foul       (Foul),
      .Timeout    (Timeout),
      .TimeH      (TimeH),
      .TimeL      (TimeL),
      .Beep       (Beep)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 armed, 2 locked, 3 foul, 4 timeout
   int            m_mode, m_win, m_total, m_e, m_disp;
   bit            m_beep, m_first;
   logic          m_prev_start;
   logic [NP-1:0] m_prev_key;

   function automatic int clamp9(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   function automatic int lowest(input logic [NP-1:0] v);
      for (int i = 0; i < NP; i++) if (v[i]) return i + 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_win = 0; m_total = 0; m_e = 0; m_disp = 0;
      m_beep = 0; m_first = 1; m_prev_start = 0; m_prev_key = '0;
   endtask

   task automatic model_step(input logic st, input logic cl, input logic [NP-1:0] k,
                             input int h, input int l);
      logic [NP-1:0] ke;
      bit            se;
      int            old;
      ke = m_first ? '0 : (k & ~m_prev_key);
      se = !m_first && st && !m_prev_start;
      m_prev_key = k; m_prev_start = st; m_first = 0;
      old = m_mode;
      if (cl) begin
         m_mode = 0; m_win = 0; m_disp = 0;
      end else begin
         case (m_mode)
            0: if (ke != 0) begin
                  m_mode = 3; m_win = lowest(ke);
               end else if (se) begin
                  m_mode = 1; m_total = clamp9(h) * 10 + clamp9(l);
                  m_e = 0; m_disp = m_total;
               end
            1: if (ke != 0) begin
                  m_mode = 2; m_win = lowest(ke);
               end else begin
                  m_e++;
                  if (m_e == m_total * TD + 1) m_mode = 4;
                  else m_disp = m_total - m_e / TD;
               end
            default: ;
         endcase
      end
      m_beep = !cl && (m_mode != old) && (m_mode >= 2);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},   int'(State),     m_mode);
      check({tag, ".winner"},  int'(Winner_ID), m_win);
      check({tag, ".foul"},    int'(Foul),      (m_mode == 3) ? 1 : 0);
      check({tag, ".timeout"}, int'(Timeout),   (m_mode == 4) ? 1 : 0);
      check({tag, ".timeh"},   int'(TimeH),     m_disp / 10);
      check({tag, ".timel"},   int'(TimeL),     m_disp % 10);
      check({tag, ".beep"},    int'(Beep),      m_beep ? 1 : 0);
   endtask

   // Drive inputs away from the edge, clock once, update model, compare.
   task automatic drive_cycle(input logic st, input logic cl, input logic [NP-1:0] k,
                              input string tag);
      Start = st; Clear = cl; Key = k;
      @(posedge CLK);
      model_step(st, cl, k, int'(TimerH_Set), int'(TimerL_Set));
      #1;
      check_all(tag);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, tag);
   endtask

   initial begin
      RSTn = 1'b0; Start = 1'b0; Clear = 1'b0; Key = '0;
      TimerH_Set = 4'd0; TimerL_Set = 4'd0;
      model_reset();
      #12;
      check_all("reset");
      RSTn = 1'b1;
      idle_cycles(2, "post_reset");

      // 1: preset 19, lock player 3 after 10 cycles, time frozen
      TimerH_Set = 4'd1; TimerL_Set = 4'd9;
      drive_cycle(1'b1, 1'b0, '0, "t1_start");
      check("t1_armed", int'(State), 1);
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, '0, "t1_wait");
      drive_cycle(1'b0, 1'b0, 6'b000100, "t1_key");
      check("t1_winner", int'(Winner_ID), 3);
      check("t1_beep", int'(Beep), 1);
      check("t1_locked", int'(State), 2);
      check("t1_time", int'(TimeL), 7);
      for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 6'b000100, "t1_hold");
      check("t1_frozen", int'(TimeL), 7);
      drive_cycle(1'b0, 1'b1, '0, "t1_clear");

      // 2: preset 02, count down and time out; preset change mid-run ignored
      TimerH_Set = 4'd0; TimerL_Set = 4'd2;
      drive_cycle(1'b1, 1'b0, '0, "t2_start");
      TimerL_Set = 4'd7;
      for (int i = 1; i <= 9; i++) begin
         drive_cycle(1'b0, 1'b0, '0, "t2_run");
         if (i == 4) check("t2_one", int'(TimeL), 1);
         if (i == 8) check("t2_zero", int'(TimeL), 0);
      end
      check("t2_timeout", int'(State), 4);
      check("t2_beep", int'(Beep), 1);
      drive_cycle(1'b0, 1'b0, '0, "t2_after");
      check("t2_beep_off", int'(Beep), 0);
      drive_cycle(1'b0, 1'b1, '0, "t2_clear");

      // 3: foul in IDLE, Start ignored, Clear restores
      drive_cycle(1'b0, 1'b0, 6'b010000, "t3_foul");
      check("t3_winner", int'(Winner_ID), 5);
      check("t3_foul_flag", int'(Foul), 1);
      drive_cycle(1'b0, 1'b0, '0, "t3_rel");
      drive_cycle(1'b1, 1'b0, '0, "t3_start");
      check("t3_still_foul", int'(State), 3);
      drive_cycle(1'b0, 1'b1, '0, "t3_clear");
      drive_cycle(1'b0, 1'b1, '0, "t3_clear2");
      check("t3_idle", int'(State), 0);
      drive_cycle(1'b0, 1'b0, '0, "t3_rel2");
      drive_cycle(1'b1, 1'b0, 6'b000001, "t3_foul_vs_start");
      check("t3_foul_wins", int'(State), 3);
      drive_cycle(1'b0, 1'b1, '0, "t3_clear3");

      // 4: simultaneous keys, lowest wins; later key ignored
      TimerH_Set = 4'd3; TimerL_Set = 4'd5;
      drive_cycle(1'b1, 1'b0, '0, "t4_start");
      idle_cycles(3, "t4_wait");
      drive_cycle(1'b0, 1'b0, 6'b100010, "t4_keys");
      check("t4_winner", int'(Winner_ID), 2);
      drive_cycle(1'b0, 1'b0, '0, "t4_rel");
      drive_cycle(1'b0, 1'b0, 6'b000001, "t4_late");
      check("t4_winner_kept", int'(Winner_ID), 2);
      drive_cycle(1'b0, 1'b1, '0, "t4_clear");

      // 5: borrow on 10 -> 09, immediate timeout on 00, clamp of 15/12
      TimerH_Set = 4'd1; TimerL_Set = 4'd0;
      drive_cycle(1'b1, 1'b0, '0, "t5_start");
      idle_cycles(4, "t5_tick");
      check("t5_h", int'(TimeH), 0);
      check("t5_l", int'(TimeL), 9);
      drive_cycle(1'b0, 1'b1, '0, "t5_clear");
      TimerH_Set = 4'd0; TimerL_Set = 4'd0;
      drive_cycle(1'b1, 1'b0, '0, "t5_start00");
      drive_cycle(1'b0, 1'b0, '0, "t5_to");
      check("t5_timeout", int'(State), 4);
      drive_cycle(1'b0, 1'b1, '0, "t5_clear2");
      TimerH_Set = 4'd15; TimerL_Set = 4'd12;
      drive_cycle(1'b1, 1'b0, '0, "t5_clamp");
      check("t5_clamp_h", int'(TimeH), 9);
      check("t5_clamp_l", int'(TimeL), 9);
      drive_cycle(1'b0, 1'b1, '0, "t5_clear3");

      // 6: asynchronous reset mid-ARMED, key held through release
      TimerH_Set = 4'd2; TimerL_Set = 4'd0;
      drive_cycle(1'b1, 1'b0, '0, "t6_start");
      idle_cycles(5, "t6_run");
      Start = 1'b0; Key = 6'b001000;
      #2;
      RSTn = 1'b0;
      #1;
      model_reset();
      check_all("t6_async");
      @(posedge CLK);
      #1;
      check_all("t6_in_reset");
      RSTn = 1'b1;
      drive_cycle(1'b0, 1'b0, 6'b001000, "t6_held");
      drive_cycle(1'b0, 1'b0, 6'b001000, "t6_held2");
      check("t6_no_edge", int'(State), 0);
      drive_cycle(1'b0, 1'b0, '0, "t6_rel");
      drive_cycle(1'b0, 1'b0, 6'b001000, "t6_press");
      check("t6_foul", int'(Winner_ID), 4);
      drive_cycle(1'b0, 1'b1, '0, "t6_clear");

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic          st, cl;
         logic [NP-1:0] k;
         TimerH_Set = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         TimerL_Set = 4'($urandom_range(0, 15));
         st = ($urandom_range(0, 7) == 0);
         cl = ($urandom_range(0, 59) == 0);
         k  = ($urandom_range(0, 29) == 0) ? NP'($urandom) : '0;
         drive_cycle(st, cl, k, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
